lsu_mem_ctrl: RTL and testbench

- Load/store access controller sitting between the execute stage and the byte-enable single-port data BRAM.
- Accepts one load/store request at a time over a valid/ready handshake and generates the BRAM enable, write-enable, byte address, lane-replicated write data and 4-bit byte write mask.
- Sequences the BRAM's one-cycle registered-address read and extracts/sign-extends LB/LH/LW/LBU/LHU results.
- Flags misaligned or illegal-funct3 accesses without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store sequencer in front of a
// byte-enable single-port BRAM whose read address is registered (one-cycle read).
// Decodes RV32I widths, rejects illegal/misaligned accesses without touching
// memory, replicates store data across lanes and extracts/extends load lanes.
module lsu_mem_ctrl #(
  parameter int DEPTH = 4096,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [XLEN-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [3:0]               mem_byte_we,
  input  logic [XLEN-1:0]          mem_rdata
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic            f3_legal, misaligned, req_err;
  logic [XLEN-1:0] st_lanes, ld_data;
  logic [3:0]      st_be;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // High address bits only matter through truncation (wrap modulo DEPTH).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  // Decode the incoming request: legality, alignment and replicated store lanes.
  always_comb begin
    f3_legal   = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                        : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    req_err    = !f3_legal || misaligned;
    case (req_funct3[1:0])
      2'b00:   st_lanes = {4{req_wdata[7:0]}};
      2'b01:   st_lanes = {2{req_wdata[15:0]}};
      default: st_lanes = req_wdata;
    endcase
  end

  // Byte write mask for the latched store, positioned by the low address bits.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   st_be = 4'b0001 << mem_addr_q[1:0];
      2'b01:   st_be = mem_addr_q[1] ? 4'b1100 : 4'b0011;
      default: st_be = 4'b1111;
    endcase
  end

  // Select and extend the load lane from the BRAM output word.
  always_comb begin
    case (mem_addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = mem_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: errors skip memory, stores skip the read wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = req_err ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; memory strobes are suppressed while reset is high.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_byte_we = 4'b0000;
    case (state_q)
      S_IDLE:  req_ready = !rst;
      S_ISSUE: begin
        mem_en      = !rst;
        mem_we      = we_q && !rst;
        mem_byte_we = (we_q && !rst) ? st_be : 4'b0000;
      end
      S_WAIT:  mem_en = !rst;
      S_RESP:  resp_valid = !rst;
      default: ;
    endcase
  end

  // Datapath next values: latch at accept, capture load data as WAIT ends.
  always_comb begin
    we_d         = we_q;
    f3_d         = f3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        we_d         = req_we;
        f3_d         = req_funct3;
        resp_err_d   = req_err;
        resp_rdata_d = '0;
        // Memory-facing regs hold their last values across rejected requests.
        if (!req_err) begin
          mem_addr_d = req_addr[AW-1:0];
          if (req_we) mem_wdata_d = st_lanes;
        end
      end
      S_WAIT:  resp_rdata_d = ld_data;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      f3_q         <= f3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: byte-array reference memory, behavioural
// BRAM model (registered address, falling-edge dataOut), queued expectations.
module tb_lsu_mem_ctrl;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_en, mem_we;
  logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_byte_we;

  lsu_mem_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_we(mem_byte_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Behavioural BRAM: byte-enable write and address register on rising edge,
  // dataOut refreshed on the falling edge.
  logic [31:0]   ram [DEPTH/4];
  logic [AW-3:0] ram_a;
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int w = 0; w < DEPTH/4; w++)
        ram[w] <= {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
      ram_init <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_byte_we[b]) ram[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      ram_a <= mem_addr[AW-1:2];
    end
  end
  always @(negedge clk) mem_rdata <= ram[ram_a];

  // Reference memory and scoreboards.
  logic [7:0] ref_mem [DEPTH];
  typedef struct {logic [31:0] rdata; logic err; int cyc;} resp_t;
  typedef struct {logic [AW-1:0] addr; logic [3:0] be; logic [31:0] data;} wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  bit    no_mem = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: RV32I load/store semantics on a flat byte array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output resp_t r, output int lat, output wr_t w);
    int          sz = 1 << f3[1:0];
    int          am = int'(a % DEPTH);
    logic        legal;
    logic [31:0] v, mask;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    r.rdata = '0;
    r.err   = !legal || (a % sz != 0);
    w.addr  = AW'(am);
    w.be    = '0;
    w.data  = '0;
    if (r.err) lat = 1;
    else if (we) begin
      lat = 2;
      for (int i = 0; i < sz; i++) begin
        w.be[(am + i) % 4] = 1'b1;
        ref_mem[am + i] = d[8*i +: 8];
      end
      for (int b = 0; b < 4; b++) w.data[8*b +: 8] = d[8*(b % sz) +: 8];
    end else begin
      lat = 3;
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[am + i]) << (8*i));
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      r.rdata = v;
    end
  endtask

  // Issue one request and wait for its response handshake.
  // mode 0: consumer always ready; 1: random back-pressure; 2: hold 5 cycles.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int mode);
    resp_t r;
    wr_t   w;
    int    lat, t, hold;
    bit    done, fin;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    t = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      if (++t > 50) begin fail("req_ready_timeout"); req_valid = 1'b0; return; end
    end
    model(we, f3, a, d, r, lat, w);
    r.cyc = cyc + lat;
    rq.push_back(r);
    if (!r.err && we) wq.push_back(w);
    no_mem = r.err;
    @(posedge clk); #1;
    // Later changes to req_* must be ignored.
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    t = 0; hold = 0; done = 1'b0;
    while (!done) begin
      if (mode == 2)      resp_ready = resp_valid && hold >= 5;
      else if (mode == 1) resp_ready = ($urandom_range(0, 3) != 0);
      else                resp_ready = 1'b1;
      fin = resp_valid && resp_ready;
      if (mode == 2 && resp_valid) hold++;
      @(posedge clk); #1;
      if (fin) done = 1'b1;
      else if (++t > 100) begin fail("resp_timeout"); done = 1'b1; end
    end
    no_mem = 1'b0;
    resp_ready = 1'b1;
    if (mode == 2) chk("req_ready_after_release", 32'(req_ready), 32'd1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a memory write or response.
  logic [31:0] hold_rd;
  logic        hold_err;
  bit          in_resp = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_byte_we", 32'(mem_byte_we), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      in_resp = 1'b0;
    end else begin
      if (no_mem) chk("err_no_mem_en", 32'(mem_en), 32'd0);
      if (mem_en && mem_we) begin
        if (wq.size() == 0) fail("unexpected_mem_write");
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_byte_we", 32'(mem_byte_we), 32'(w.be));
          chk("wr_data", mem_wdata, w.data);
        end
      end else if (mem_en) chk("load_byte_we", 32'(mem_byte_we), 32'd0);
      if (resp_valid) begin
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        if (!in_resp) begin
          if (rq.size() == 0) fail("unexpected_resp");
          else begin
            resp_t r;
            r = rq.pop_front();
            chk("resp_rdata", resp_rdata, r.rdata);
            chk("resp_err", 32'(resp_err), 32'(r.err));
            chk("resp_latency_cyc", 32'(cyc), 32'(r.cyc));
          end
          hold_rd  = resp_rdata;
          hold_err = resp_err;
          in_resp  = 1'b1;
        end else begin
          chk("resp_rdata_stable", resp_rdata, hold_rd);
          chk("resp_err_stable", 32'(resp_err), 32'(hold_err));
        end
        if (resp_ready) in_resp = 1'b0;
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_resp_rdata", resp_rdata, 32'd0);
    chk("post_rst_resp_err", 32'(resp_err), 32'd0);
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);

    // Word store/load
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 0);
    // Byte store into that word, then LW/LB/LBU
    issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 0);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 0);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 0);
    // Halfword store, LH/LHU
    issue(1'b1, 3'b001, 32'h22, 32'h00008001, 0);
    issue(1'b0, 3'b001, 32'h22, 32'h0, 0);
    issue(1'b0, 3'b101, 32'h22, 32'h0, 0);
    // Error cases, then confirm memory untouched
    issue(1'b0, 3'b010, 32'h05, 32'h0, 0);
    issue(1'b1, 3'b001, 32'h03, 32'hFFFFFFFF, 0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 0);
    // Response back-pressure
    issue(1'b0, 3'b010, 32'h20, 32'h0, 2);

    // Reset during the ISSUE cycle of a store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h12345678;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_byte_we", 32'(mem_byte_we), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("abort_post_rst_resp_valid", 32'(resp_valid), 32'd0);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 0);
    // Wrap above DEPTH aliases onto low memory without error
    issue(1'b0, 3'b010, 32'h10 + DEPTH, 32'h0, 0);

    // Randomized traffic in a small window (with wrapped aliases)
    for (int n = 0; n < 250; n++) begin
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && f3 <= 3'd1) f3[2] = 1'b1;
      a = 32'($urandom_range(0, 95));
      if ($urandom_range(0, 5) == 0) a = a + ($urandom & 32'hFFFF_F000);
      issue(1'($urandom), f3, a, $urandom, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
